// File: rtl/warp_issue_ctrl_pkg.sv
// Shared warp scheduling defines: slot count, field widths, per-warp state.
package warp_issue_ctrl_pkg;

    localparam int NUM_WARPS_PER_SM = 4;
    localparam int WARP_ID_WIDTH    = $clog2(NUM_WARPS_PER_SM);
    localparam int LAT_W            = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } warp_state_t;

endpackage

// File: rtl/warp_issue_ctrl_warp_slot.sv
// One warp slot: lifecycle state machine plus post-issue latency counter.
module warp_slot
    import warp_issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_launch,
    input  logic             i_flush,
    input  logic             i_accept,
    input  logic             i_halt,
    input  logic [LAT_W-1:0] i_latency,
    output warp_state_t      o_state,
    output logic             o_request
);

    warp_state_t      r_state;
    warp_state_t      w_state_nxt;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (i_launch) begin
                        w_state_nxt = READY;
                        w_cnt_nxt   = '0;
                    end
                end
                READY: begin
                    if (i_accept) begin
                        if (i_halt) begin
                            w_state_nxt = DONE;
                            w_cnt_nxt   = '0;
                        end else if (i_latency != '0) begin
                            w_state_nxt = WAIT;
                            w_cnt_nxt   = i_latency;
                        end
                    end
                end
                WAIT: begin
                    // cnt==1 is the last stalled cycle; <=1 also recovers from 0
                    if (r_cnt <= LAT_W'(1)) begin
                        w_state_nxt = READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - LAT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_request = (r_state == READY);

endmodule

// File: rtl/warp_issue_ctrl.sv
// Requester side of the warp arbiter handshake: per-warp slots, grant
// acceptance with lowest-index pick, and the registered issue pulse.
module warp_issue_ctrl
    import warp_issue_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_WARPS_PER_SM-1:0] warp_launch,
    input  logic [NUM_WARPS_PER_SM-1:0] warp_flush,
    input  logic [NUM_WARPS_PER_SM-1:0] grantOH,
    input  logic                        issue_stall,
    input  logic [LAT_W-1:0]            issue_latency,
    input  logic                        issue_halt,
    output logic [NUM_WARPS_PER_SM-1:0] request,
    output logic                        issue_valid,
    output logic [WARP_ID_WIDTH-1:0]    issue_warp_id,
    output logic [NUM_WARPS_PER_SM-1:0] issue_warp_oh,
    output logic [NUM_WARPS_PER_SM-1:0] active_mask,
    output logic                        sm_idle
);

    localparam int N = NUM_WARPS_PER_SM;

    warp_state_t              w_state [N];
    logic [N-1:0]             w_req;
    logic [N-1:0]             w_acc;
    logic [N-1:0]             w_pick;
    logic [WARP_ID_WIDTH-1:0] w_pick_id;
    logic                     w_issue;
    logic [N-1:0]             w_active;

    logic                     r_issue_valid;
    logic [WARP_ID_WIDTH-1:0] r_issue_warp_id;
    logic [N-1:0]             r_issue_warp_oh;

    for (genvar g = 0; g < N; g++) begin : g_slot
        warp_slot u_slot (
            .clk       (clk),
            .reset     (reset),
            .i_launch  (warp_launch[g]),
            .i_flush   (warp_flush[g]),
            .i_accept  (w_pick[g]),
            .i_halt    (issue_halt),
            .i_latency (issue_latency),
            .o_state   (w_state[g]),
            .o_request (w_req[g])
        );
    end

    // The arbiter grants by default even with no requests; mask those out.
    assign w_acc  = grantOH & w_req & {N{~issue_stall}};
    assign w_pick = w_acc & (~w_acc + N'(1));

    always_comb begin
        w_pick_id = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick[i]) w_pick_id = WARP_ID_WIDTH'(i);
        end
    end

    // A flushed warp still consumes its grant but produces no issue.
    assign w_issue = |(w_pick & ~warp_flush);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_valid   <= 1'b0;
            r_issue_warp_id <= '0;
            r_issue_warp_oh <= '0;
        end else begin
            r_issue_valid <= w_issue;
            if (w_issue) begin
                r_issue_warp_id <= w_pick_id;
                r_issue_warp_oh <= w_pick;
            end
        end
    end

    always_comb begin
        w_active = '0;
        for (int i = 0; i < N; i++) begin
            w_active[i] = (w_state[i] == READY) || (w_state[i] == WAIT);
        end
    end

    assign request       = w_req;
    assign issue_valid   = r_issue_valid;
    assign issue_warp_id = r_issue_warp_id;
    assign issue_warp_oh = r_issue_warp_oh;
    assign active_mask   = w_active;
    assign sm_idle       = ~|w_active;

endmodule

// File: tb/tb_warp_issue_ctrl.sv
// Bench for warp_issue_ctrl: directed vector table, async reset case,
// and random traffic against a cycle-count based reference model.
module tb_warp_issue_ctrl;
    import warp_issue_ctrl_pkg::*;

    localparam int N  = NUM_WARPS_PER_SM;
    localparam int IW = WARP_ID_WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     warp_launch;
    logic [N-1:0]     warp_flush;
    logic [N-1:0]     grantOH;
    logic             issue_stall;
    logic [LAT_W-1:0] issue_latency;
    logic             issue_halt;
    logic [N-1:0]     request;
    logic             issue_valid;
    logic [IW-1:0]    issue_warp_id;
    logic [N-1:0]     issue_warp_oh;
    logic [N-1:0]     active_mask;
    logic             sm_idle;

    int n_tests = 0;
    int n_fail  = 0;

    warp_issue_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .warp_launch   (warp_launch),
        .warp_flush    (warp_flush),
        .grantOH       (grantOH),
        .issue_stall   (issue_stall),
        .issue_latency (issue_latency),
        .issue_halt    (issue_halt),
        .request       (request),
        .issue_valid   (issue_valid),
        .issue_warp_id (issue_warp_id),
        .issue_warp_oh (issue_warp_oh),
        .active_mask   (active_mask),
        .sm_idle       (sm_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]     launch;
        logic [N-1:0]     flush;
        logic [N-1:0]     grant;
        logic             stall;
        logic [LAT_W-1:0] lat;
        logic             halt;
        logic [N-1:0]     req;
        logic             vld;
        logic [IW-1:0]    id;
        logic [N-1:0]     oh;
        logic [N-1:0]     act;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [N-1:0] l, logic [N-1:0] f,
                                logic [N-1:0] g, logic s,
                                logic [LAT_W-1:0] lt, logic h,
                                logic [N-1:0] rq, logic v,
                                logic [IW-1:0] id, logic [N-1:0] oh,
                                logic [N-1:0] act);
        vec_t r;
        r.launch = l;  r.flush = f; r.grant = g; r.stall = s;
        r.lat = lt;    r.halt = h;  r.req = rq;  r.vld = v;
        r.id = id;     r.oh = oh;   r.act = act;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic [N-1:0] l, logic [N-1:0] f, logic [N-1:0] g,
                         logic s, logic [LAT_W-1:0] lt, logic h);
        warp_launch = l; warp_flush = f; grantOH = g;
        issue_stall = s; issue_latency = lt; issue_halt = h;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, ".request"}, 32'(request), 32'(0));
        chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(0));
        chk({tag, ".issue_warp_id"}, 32'(issue_warp_id), 32'(0));
        chk({tag, ".issue_warp_oh"}, 32'(issue_warp_oh), 32'(0));
        chk({tag, ".active_mask"}, 32'(active_mask), 32'(0));
        chk({tag, ".sm_idle"}, 32'(sm_idle), 32'(1));
    endtask

    // Reference model: a warp is alive between launch and halt/flush and
    // requests once the cycle counter reaches its wake-up cycle.
    bit            m_alive [N];
    int            m_wake  [N];
    int            cyc;
    logic          m_vld;
    logic [IW-1:0] m_id;
    logic [N-1:0]  m_oh;

    function automatic logic [N-1:0] m_req();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_alive[i] && (cyc >= m_wake[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_alive[i] = 0;
            m_wake[i]  = 0;
        end
        cyc = 0; m_vld = 0; m_id = '0; m_oh = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] acc;
        int pick;
        acc  = grantOH & m_req() & {N{~issue_stall}};
        pick = -1;
        for (int i = N - 1; i >= 0; i--) if (acc[i]) pick = i;
        for (int i = 0; i < N; i++) begin
            if (warp_flush[i]) begin
                m_alive[i] = 0;
            end else if (pick == i) begin
                if (issue_halt) m_alive[i] = 0;
                else m_wake[i] = cyc + int'(issue_latency) + 1;
            end else if (warp_launch[i] && !m_alive[i]) begin
                m_alive[i] = 1;
                m_wake[i]  = cyc + 1;
            end
        end
        m_vld = (pick >= 0) && !warp_flush[pick];
        if (m_vld) begin
            m_id = IW'(pick);
            m_oh = N'(1) << pick;
        end
        cyc++;
    endtask

    logic [N-1:0] rq;
    int           idx;

    initial begin
        drive('0, '0, '0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;

        //        launch   flush    grant    st lat    h   req      v  id     oh       act
        tbl.push_back(mk(4'b0101, 4'b0000, 4'b0001, 0, 4'd0, 0, 4'b0101, 0, 2'd0, 4'b0000, 4'b0101));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0001, 0, 4'd0, 0, 4'b0101, 1, 2'd0, 4'b0001, 4'b0101));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0001, 0, 4'd0, 0, 4'b0101, 1, 2'd0, 4'b0001, 4'b0101));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0100, 0, 4'd3, 0, 4'b0001, 1, 2'd2, 4'b0100, 4'b0101));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 4'd0, 0, 4'b0001, 0, 2'd2, 4'b0100, 4'b0101));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 4'd0, 0, 4'b0001, 0, 2'd2, 4'b0100, 4'b0101));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 4'd0, 0, 4'b0101, 0, 2'd2, 4'b0100, 4'b0101));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b1000, 0, 4'd0, 0, 4'b0111, 0, 2'd2, 4'b0100, 4'b0111));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0010, 1, 4'd0, 0, 4'b0111, 0, 2'd2, 4'b0100, 4'b0111));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0010, 1, 4'd0, 0, 4'b0111, 0, 2'd2, 4'b0100, 4'b0111));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0010, 0, 4'd0, 0, 4'b0111, 1, 2'd1, 4'b0010, 4'b0111));
        tbl.push_back(mk(4'b1000, 4'b0000, 4'b0000, 0, 4'd0, 0, 4'b1111, 0, 2'd1, 4'b0010, 4'b1111));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b1000, 0, 4'd5, 1, 4'b0111, 1, 2'd3, 4'b1000, 4'b0111));
        tbl.push_back(mk(4'b1000, 4'b0000, 4'b0000, 0, 4'd0, 0, 4'b1111, 0, 2'd3, 4'b1000, 4'b1111));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b1000, 0, 4'd2, 0, 4'b0111, 1, 2'd3, 4'b1000, 4'b1111));
        tbl.push_back(mk(4'b1000, 4'b0000, 4'b0000, 0, 4'd0, 0, 4'b0111, 0, 2'd3, 4'b1000, 4'b1111));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 4'd0, 0, 4'b1111, 0, 2'd3, 4'b1000, 4'b1111));
        tbl.push_back(mk(4'b0000, 4'b0001, 4'b0001, 0, 4'd0, 0, 4'b1110, 0, 2'd3, 4'b1000, 4'b1110));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b1010, 0, 4'd0, 0, 4'b1110, 1, 2'd1, 4'b0010, 4'b1110));
        tbl.push_back(mk(4'b0000, 4'b1110, 4'b0000, 0, 4'd0, 0, 4'b0000, 0, 2'd1, 4'b0010, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b1000, 0, 4'd0, 0, 4'b0000, 0, 2'd1, 4'b0010, 4'b0000));

        for (int k = 0; k < tbl.size(); k++) begin
            string t;
            t = $sformatf("vec%0d", k);
            @(negedge clk);
            drive(tbl[k].launch, tbl[k].flush, tbl[k].grant,
                  tbl[k].stall, tbl[k].lat, tbl[k].halt);
            @(posedge clk);
            #1;
            chk({t, ".request"}, 32'(request), 32'(tbl[k].req));
            chk({t, ".issue_valid"}, 32'(issue_valid), 32'(tbl[k].vld));
            chk({t, ".issue_warp_id"}, 32'(issue_warp_id), 32'(tbl[k].id));
            chk({t, ".issue_warp_oh"}, 32'(issue_warp_oh), 32'(tbl[k].oh));
            chk({t, ".active_mask"}, 32'(active_mask), 32'(tbl[k].act));
            chk({t, ".sm_idle"}, 32'(sm_idle), 32'(tbl[k].act == '0));
        end

        // Async reset with warps waiting and an issue pulse on the output
        @(negedge clk); drive(4'b1111, '0, '0, 1'b0, 4'd0, 1'b0);
        @(negedge clk); drive('0, '0, 4'b0001, 1'b0, 4'd7, 1'b0);
        @(negedge clk); drive('0, '0, 4'b0010, 1'b0, 4'd7, 1'b0);
        @(negedge clk); drive('0, '0, 4'b0100, 1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst.pre_valid", 32'(issue_valid), 32'(1));
        chk("midrst.pre_active", 32'(active_mask), 32'(4'b1111));
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        drive('0, '0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            rq = m_req();
            warp_launch   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            warp_flush    = ($urandom_range(0, 15) == 0) ?
                            (N'(1) << $urandom_range(0, N - 1)) : '0;
            if (rq != '0 && $urandom_range(0, 3) != 0) begin
                do idx = int'($urandom_range(0, N - 1)); while (!rq[idx]);
                grantOH = N'(1) << idx;
            end else if ($urandom_range(0, 7) == 0) begin
                grantOH = N'($urandom);
            end else begin
                grantOH = N'(1) << $urandom_range(0, N - 1);
            end
            issue_stall   = ($urandom_range(0, 4) == 0);
            issue_latency = LAT_W'($urandom_range(0, 5));
            issue_halt    = ($urandom_range(0, 9) == 0);
            model_step();
            @(posedge clk);
            #1;
            chk("rnd.request", 32'(request), 32'(m_req()));
            chk("rnd.issue_valid", 32'(issue_valid), 32'(m_vld));
            chk("rnd.issue_warp_id", 32'(issue_warp_id), 32'(m_id));
            chk("rnd.issue_warp_oh", 32'(issue_warp_oh), 32'(m_oh));
            begin
                logic [N-1:0] am;
                for (int i = 0; i < N; i++) am[i] = m_alive[i];
                chk("rnd.active_mask", 32'(active_mask), 32'(am));
                chk("rnd.sm_idle", 32'(sm_idle), 32'(am == '0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/warp_issue_ctrl.md
Name: warp_issue_ctrl

Overview:
- Requester side of the per-SM warp scheduling handshake. Holds one state machine and latency counter per warp, and drives the per-warp request vector into the round-robin warp arbiter.
- Consumes the arbiter's one-hot grant and turns an accepted grant into a registered issue pulse toward decode/issue.
- Handles warp launch, halt and flush.

Parameters:
- NUM_WARPS_PER_SM, 4, number of warp slots; taken from the shared defines package.
- LAT_W, 4, width of the per-issue latency field.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- warp_launch  in  NUM_WARPS_PER_SM  per-warp launch strobe
- warp_flush  in  NUM_WARPS_PER_SM  per-warp kill strobe
- grantOH  in  NUM_WARPS_PER_SM  one-hot grant from the arbiter; combinational from request
- issue_stall  in  1  downstream backpressure; no grant is accepted while high
- issue_latency  in  LAT_W  cycles the granted warp must wait before re-requesting; sampled with the accepted grant
- issue_halt  in  1  the granted warp's instruction is its last; sampled with the accepted grant
- request  out  NUM_WARPS_PER_SM  warps eligible for issue
- issue_valid  out  1  registered pulse, one per accepted grant
- issue_warp_id  out  $clog2(NUM_WARPS_PER_SM)  id of the issued warp
- issue_warp_oh  out  NUM_WARPS_PER_SM  one-hot of the issued warp
- active_mask  out  NUM_WARPS_PER_SM  warp is in READY or WAIT
- sm_idle  out  1  no warp in READY or WAIT

Behaviour:
- Per-warp states: IDLE, READY, WAIT, DONE.
- Reset: all warps IDLE, counters 0. request=0, issue_valid=0, issue_warp_id=0, issue_warp_oh=0, active_mask=0, sm_idle=1.
- request[i] = (state[i]==READY). Decoded combinationally from registered state only; no input-to-request path.
- accepted = grantOH & request & {N{~issue_stall}}.
  - A grant bit on a non-requesting warp is ignored. The arbiter drives a default grant with zero requests, so this case is normal.
  - If accepted is multi-hot, only the lowest index is accepted.
- Accepted grant to warp i at edge:
  - issue_halt=1: go to DONE, ignoring latency.
  - else issue_latency==0: stay READY (back-to-back issue allowed).
  - else: go to WAIT with cnt=issue_latency.
- WAIT: if cnt==1, go to READY; else cnt-1.
  - A grant in cycle t with latency L gives request[i] low in cycles t+1..t+L and high again at t+L+1.
- issue_valid/issue_warp_id/issue_warp_oh are registered one cycle after the accepted grant (latency 1). issue_valid is 0 when nothing is accepted; id/oh hold their last value.
- warp_launch[i]:
  - From IDLE or DONE: go to READY, cnt=0.
  - In READY or WAIT: ignored.
- warp_flush[i]: any state goes to IDLE and cnt clears.
  - Same-cycle priority: flush > accepted grant > launch.
  - If a flushed warp is also accepted that cycle, the issue pulse is suppressed (issue_valid=0 next cycle).
- issue_stall high: requests stay asserted and WAIT counters keep decrementing. Stall does not freeze the counters.
- active_mask and sm_idle are combinational from registered state.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight issue pulse is dropped.

Decomposition:
- Shared defines package gets:
  - warp_state_t enum {IDLE, READY, WAIT, DONE}
  - WARP_ID_WIDTH = $clog2(NUM_WARPS_PER_SM)
  - LAT_W
- Sub-module warp_slot: one instance per warp. Contains the state FSM and latency counter. Inputs: launch, flush, accept, halt, latency. Outputs: state, request.
- Top level contains: accept qualification with lowest-index pick, one-hot-to-id encode, issue output registers, and the mask/idle logic.

Test Plan:
- Reset, then launch=4'b0101, grantOH=4'b0001 held, latency 0, no stall -> request=0101 from the cycle after launch; issue_valid every cycle with id 0 while the grant stays on warp 0.
- Launch warp 2, grant warp 2 with issue_latency=3 -> request[2] low for exactly 3 cycles, high on the 4th; one issue_valid with id=2, oh=0100, one cycle after the grant.
- All warps IDLE, grantOH=4'b1000 -> no issue_valid, no state change, sm_idle=1.
- Warp 1 READY and granted with issue_stall=1 for 2 cycles, then stall=0 -> no issue during the stall, issue_valid id=1 one cycle after stall drops.
- Warp 3 granted with issue_halt=1 -> DONE, request[3]=0, active_mask[3]=0; later launch[3] -> READY; launch during WAIT -> ignored.
- Warp 0 granted with flush[0] in the same cycle -> IDLE, no issue_valid. Separately, reset asserted while warps are in WAIT -> all outputs at reset values immediately.
